// File: rtl/snake_merge4.sv
// snake_merge4: four valid/ready lanes merged round-robin into one stream via a 2-entry buffer.
// Optional lane tagging of each buffered word is enabled with SNAKE_MERGE4_LANE_TAG_EN.
module snake_merge4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_lane
);

  logic [1:0]       ptr, ptr_d;
  logic [1:0]       count, count_d;
  logic [15:0]      beat_cnt, beat_cnt_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [WIDTH-1:0] tail_data_q, tail_data_d;

  logic             found;
  logic [1:0]       gidx;
  logic [1:0]       idx;
  logic             push, pop;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    found = 1'b0;
    gidx  = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  // Acceptance depends only on the grant and buffer occupancy, never on out_ready.
  always_comb begin
    in_ready = 4'b0000;
    if (found && (count != 2'd2) && !rst) in_ready = 4'b0001 << gidx;
  end

  assign push     = |(in_valid & in_ready);
  assign pop      = out_valid && out_ready;
  assign sel_data = in_data[gidx*WIDTH +: WIDTH];

  always_comb begin
    count_d     = count;
    ptr_d       = ptr;
    head_data_d = head_data_q;
    tail_data_d = tail_data_q;
    beat_cnt_d  = pop ? beat_cnt + 16'd1 : beat_cnt;
    if (push) ptr_d = gidx + 2'd1;
    case ({push, pop})
      2'b10: begin
        if (count == 2'd0) head_data_d = sel_data;
        else               tail_data_d = sel_data;
        count_d = count + 2'd1;
      end
      2'b01: begin
        if (count == 2'd2) head_data_d = tail_data_q;
        count_d = count - 2'd1;
      end
      2'b11: head_data_d = sel_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= 2'd0;
      ptr         <= 2'd0;
      beat_cnt    <= 16'd0;
      head_data_q <= '0;
    end else begin
      count       <= count_d;
      ptr         <= ptr_d;
      beat_cnt    <= beat_cnt_d;
      head_data_q <= head_data_d;
    end
    tail_data_q <= tail_data_d;
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = head_data_q;

`ifdef SNAKE_MERGE4_LANE_TAG_EN
  logic [1:0] head_lane_q, head_lane_d;
  logic [1:0] tail_lane_q, tail_lane_d;

  always_comb begin
    head_lane_d = head_lane_q;
    tail_lane_d = tail_lane_q;
    case ({push, pop})
      2'b10: begin
        if (count == 2'd0) head_lane_d = gidx;
        else               tail_lane_d = gidx;
      end
      2'b01: if (count == 2'd2) head_lane_d = tail_lane_q;
      2'b11: head_lane_d = gidx;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) head_lane_q <= 2'd0;
    else     head_lane_q <= head_lane_d;
    tail_lane_q <= tail_lane_d;
  end

  assign out_lane = head_lane_q;
`else
  assign out_lane = 2'b00;
`endif

endmodule
